// File: rtl/balance_pid_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : balance_pid_pipe_if
// Description : Bundle between the inertial front end (sample side) and the
//               balance controller, plus the motor speed/direction results.
//               master : pitch/steering source, consumes speed outputs
//               slave  : the balance controller
//   vld, ptch, ld_cell_diff, rider_off, en_steer, pwr_up   master -> slave
//   lft_spd, lft_rev, rght_spd, rght_rev, too_fast, spd_vld slave -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface balance_pid_pipe_if #(
    parameter int PTCH_W = 16,
    parameter int SPD_W  = 11
);
    logic                     vld;
    logic signed [PTCH_W-1:0] ptch;
    logic signed [11:0]       ld_cell_diff;
    logic                     rider_off;
    logic                     en_steer;
    logic                     pwr_up;

    logic [SPD_W-1:0]         lft_spd;
    logic                     lft_rev;
    logic [SPD_W-1:0]         rght_spd;
    logic                     rght_rev;
    logic                     too_fast;
    logic                     spd_vld;

    modport master (
        output vld, ptch, ld_cell_diff, rider_off, en_steer, pwr_up,
        input  lft_spd, lft_rev, rght_spd, rght_rev, too_fast, spd_vld
    );

    modport slave (
        input  vld, ptch, ld_cell_diff, rider_off, en_steer, pwr_up,
        output lft_spd, lft_rev, rght_spd, rght_rev, too_fast, spd_vld
    );
endinterface
`default_nettype wire

// File: rtl/balance_pid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : balance_pid_pipe
// Description : 3-stage pipelined PID balance controller for the segway drive
//               path. Pitch error plus load-cell steering difference become
//               left/right motor speed and direction, gated by a power-up
//               soft-start speed limit.
//   Stage 1 : saturate pitch to ERR_W, P term, D difference, integrator
//   Stage 2 : PID sum, steering split into left/right torque
//   Stage 3 : low-band gain / min-duty shaping, magnitude, clamp, register
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               bus    - balance_pid_pipe_if.slave (samples in, speeds out)
// Build macro : INTEG_CLAMP_EN - integrator saturates on overflow instead of
//               holding its previous value.
// Revision    : 1.0 - initial release
// ============================================================================
module balance_pid_pipe #(
    parameter int PTCH_W      = 16,
    parameter int ERR_W       = 10,
    parameter int P_COEFF     = 14,
    parameter int D_COEFF     = 20,
    parameter int D_DEPTH     = 2,
    parameter int I_SHIFT     = 6,
    parameter int LOW_BAND    = 70,
    parameter int GAIN_MULT   = 15,
    parameter int MIN_DUTY    = 980,
    parameter int SPD_W       = 11,
    parameter int TOO_FAST_TH = 1536,
    parameter int RAMP_STEP   = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    balance_pid_pipe_if.slave       bus
);

    localparam int TQ_W  = 16;
    localparam int ACC_W = 18;
    localparam int DD_W  = 7;

    localparam logic signed [PTCH_W-1:0] c_err_max = PTCH_W'((2 ** (ERR_W - 1)) - 1);
    localparam logic signed [PTCH_W-1:0] c_err_min = PTCH_W'(-(2 ** (ERR_W - 1)));
    localparam logic signed [ERR_W:0]    c_dd_max  = (ERR_W + 1)'((2 ** (DD_W - 1)) - 1);
    localparam logic signed [ERR_W:0]    c_dd_min  = (ERR_W + 1)'(-(2 ** (DD_W - 1)));
    localparam logic signed [TQ_W-1:0]   c_p_coeff = TQ_W'(P_COEFF);
    localparam logic signed [TQ_W-1:0]   c_d_coeff = TQ_W'(D_COEFF);
    localparam logic signed [TQ_W-1:0]   c_gain    = TQ_W'(GAIN_MULT);
    localparam logic signed [TQ_W-1:0]   c_duty    = TQ_W'(MIN_DUTY);
    localparam logic [TQ_W-1:0]          c_band    = TQ_W'(LOW_BAND);
    localparam logic signed [ACC_W-1:0]  c_acc_max = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  c_acc_min = {1'b1, {(ACC_W - 1){1'b0}}};
    localparam logic [SPD_W-1:0]         c_spd_max = {SPD_W{1'b1}};
    localparam logic [SPD_W-1:0]         c_fast_th = SPD_W'(TOO_FAST_TH);
    localparam logic [SPD_W:0]           c_ramp_st = (SPD_W + 1)'(RAMP_STEP);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SOFT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [SPD_W-1:0]          r_ramp_lim;
    logic signed [ACC_W-1:0]   r_integ;
    logic signed [ERR_W-1:0]   r_hist [D_DEPTH];

    // Stage registers
    logic                      r_v1;
    logic signed [TQ_W-1:0]    r_p1;
    logic signed [TQ_W-1:0]    r_d1;
    logic signed [TQ_W-1:0]    r_i1;
    logic signed [TQ_W-1:0]    r_steer1;
    logic                      r_v2;
    logic signed [TQ_W-1:0]    r_lft2;
    logic signed [TQ_W-1:0]    r_rght2;

    // Output registers
    logic [SPD_W-1:0]          r_lft_spd;
    logic                      r_lft_rev;
    logic [SPD_W-1:0]          r_rght_spd;
    logic                      r_rght_rev;
    logic                      r_too_fast;
    logic                      r_spd_vld;

    // ------------------------------------------------------------------
    // Control: the whole datapath is held empty whenever power is off or
    // the FSM has not yet left OFF; this also discards in-flight samples.
    // ------------------------------------------------------------------
    logic w_flush;
    logic w_accept;
    logic w_hist_clr;

    assign w_flush    = !bus.pwr_up || (r_state == ST_OFF);
    assign w_accept   = bus.vld && !w_flush;
    assign w_hist_clr = w_flush || bus.rider_off;

    // ------------------------------------------------------------------
    // Stage 1 combinational
    // ------------------------------------------------------------------
    logic signed [ERR_W-1:0]  w_err;
    logic signed [ERR_W:0]    w_ddiff_full;
    logic signed [DD_W-1:0]   w_ddiff;
    logic signed [TQ_W-1:0]   w_err_tq;
    logic signed [TQ_W-1:0]   w_ddiff_tq;
    logic signed [TQ_W-1:0]   w_p;
    logic signed [TQ_W-1:0]   w_d;
    logic signed [TQ_W-1:0]   w_i;
    logic signed [ACC_W-1:0]  w_err_acc;
    logic signed [ACC_W-1:0]  w_integ_sum;
    logic signed [ACC_W-1:0]  w_integ_sat;
    logic signed [ACC_W-1:0]  w_integ_nxt;
    logic                     w_integ_ovf;
    logic signed [11:0]       w_ld_sh;
    logic signed [TQ_W-1:0]   w_steer;

    always_comb begin
        if (bus.ptch > c_err_max) begin
            w_err = c_err_max[ERR_W-1:0];
        end else if (bus.ptch < c_err_min) begin
            w_err = c_err_min[ERR_W-1:0];
        end else begin
            w_err = bus.ptch[ERR_W-1:0];
        end
    end

    // err[n] - err[n-D_DEPTH], one extra bit so the difference cannot wrap
    assign w_ddiff_full = {w_err[ERR_W-1], w_err}
                        - {r_hist[D_DEPTH-1][ERR_W-1], r_hist[D_DEPTH-1]};

    always_comb begin
        if (w_ddiff_full > c_dd_max) begin
            w_ddiff = c_dd_max[DD_W-1:0];
        end else if (w_ddiff_full < c_dd_min) begin
            w_ddiff = c_dd_min[DD_W-1:0];
        end else begin
            w_ddiff = w_ddiff_full[DD_W-1:0];
        end
    end

    assign w_err_tq   = TQ_W'(w_err);
    assign w_ddiff_tq = TQ_W'(w_ddiff);
    assign w_p        = w_err_tq * c_p_coeff;
    assign w_d        = w_ddiff_tq * c_d_coeff;
    // I term uses the accumulator before this sample is added
    assign w_i        = TQ_W'(r_integ >>> I_SHIFT);

    assign w_err_acc   = ACC_W'(w_err);
    assign w_integ_sum = r_integ + w_err_acc;
    // Like-signed operands producing an opposite-signed result
    assign w_integ_ovf = (r_integ[ACC_W-1] == w_err_acc[ACC_W-1])
                      && (w_integ_sum[ACC_W-1] != r_integ[ACC_W-1]);

`ifdef INTEG_CLAMP_EN
    assign w_integ_sat = r_integ[ACC_W-1] ? c_acc_min : c_acc_max;
`else
    assign w_integ_sat = r_integ;
`endif

    assign w_integ_nxt = w_integ_ovf ? w_integ_sat : w_integ_sum;

    assign w_ld_sh = bus.ld_cell_diff >>> 3;
    assign w_steer = bus.en_steer ? TQ_W'(w_ld_sh) : '0;

    // D history and integrator; a clear (rider off / power off) beats vld
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_integ <= '0;
            for (int i = 0; i < D_DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else if (w_hist_clr) begin
            r_integ <= '0;
            for (int i = 0; i < D_DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else if (w_accept) begin
            r_integ   <= w_integ_nxt;
            r_hist[0] <= w_err;
            for (int i = 1; i < D_DEPTH; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_p1     <= '0;
            r_d1     <= '0;
            r_i1     <= '0;
            r_steer1 <= '0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_p1     <= w_p;
                r_d1     <= w_d;
                r_i1     <= w_i;
                r_steer1 <= w_steer;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: PID sum and steering split
    // ------------------------------------------------------------------
    logic signed [TQ_W-1:0] w_pid;

    assign w_pid = r_p1 + r_d1 + r_i1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_lft2  <= '0;
            r_rght2 <= '0;
        end else begin
            r_v2 <= r_v1 && !w_flush;
            if (r_v1) begin
                r_lft2  <= w_pid - r_steer1;
                r_rght2 <= w_pid + r_steer1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: shaping, magnitude and speed limit
    // ------------------------------------------------------------------
    function automatic logic [TQ_W-1:0] f_abs(input logic signed [TQ_W-1:0] t);
        f_abs = t[TQ_W-1] ? TQ_W'(-t) : TQ_W'(t);
    endfunction

    // Small torques get a gain; larger ones get the motor's dead-band offset
    function automatic logic signed [TQ_W-1:0] f_shape(input logic signed [TQ_W-1:0] t);
        if (f_abs(t) >= c_band) begin
            f_shape = t[TQ_W-1] ? (t - c_duty) : (t + c_duty);
        end else begin
            f_shape = t * c_gain;
        end
    endfunction

    // ramp_lim never exceeds the SPD_W maximum, so limiting against it
    // also covers the output-width clamp.
    function automatic logic [SPD_W-1:0] f_spd(input logic signed [TQ_W-1:0] s,
                                               input logic [SPD_W-1:0]      lim);
        logic [TQ_W-1:0] mag;
        mag   = f_abs(s);
        f_spd = (mag > TQ_W'(lim)) ? lim : mag[SPD_W-1:0];
    endfunction

    logic signed [TQ_W-1:0] w_lft_shp;
    logic signed [TQ_W-1:0] w_rght_shp;
    logic [SPD_W-1:0]       w_lft_spd;
    logic [SPD_W-1:0]       w_rght_spd;

    assign w_lft_shp  = f_shape(r_lft2);
    assign w_rght_shp = f_shape(r_rght2);
    assign w_lft_spd  = f_spd(w_lft_shp, r_ramp_lim);
    assign w_rght_spd = f_spd(w_rght_shp, r_ramp_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_spd  <= '0;
            r_lft_rev  <= 1'b0;
            r_rght_spd <= '0;
            r_rght_rev <= 1'b0;
            r_too_fast <= 1'b0;
            r_spd_vld  <= 1'b0;
        end else if (w_flush) begin
            r_lft_spd  <= '0;
            r_lft_rev  <= 1'b0;
            r_rght_spd <= '0;
            r_rght_rev <= 1'b0;
            r_too_fast <= 1'b0;
            r_spd_vld  <= 1'b0;
        end else begin
            r_spd_vld <= r_v2;
            if (r_v2) begin
                r_lft_spd  <= w_lft_spd;
                r_lft_rev  <= w_lft_shp[TQ_W-1];
                r_rght_spd <= w_rght_spd;
                r_rght_rev <= w_rght_shp[TQ_W-1];
                r_too_fast <= (w_lft_spd > c_fast_th) || (w_rght_spd > c_fast_th);
            end
        end
    end

    // ------------------------------------------------------------------
    // Soft-start FSM: ramp limit grows one step per speed update until it
    // reaches the full output range. The increment lands on the same edge
    // that publishes the update, so that update still used the old limit.
    // ------------------------------------------------------------------
    logic [SPD_W:0] w_ramp_sum;

    assign w_ramp_sum = {1'b0, r_ramp_lim} + c_ramp_st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_OFF;
            r_ramp_lim <= '0;
        end else if (!bus.pwr_up) begin
            r_state    <= ST_OFF;
            r_ramp_lim <= '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_state    <= ST_SOFT;
                    r_ramp_lim <= '0;
                end
                ST_SOFT: begin
                    if (r_v2) begin
                        if (w_ramp_sum >= {1'b0, c_spd_max}) begin
                            r_ramp_lim <= c_spd_max;
                            r_state    <= ST_RUN;
                        end else begin
                            r_ramp_lim <= w_ramp_sum[SPD_W-1:0];
                        end
                    end
                end
                ST_RUN: begin
                    r_ramp_lim <= c_spd_max;
                end
                default: begin
                    r_state    <= ST_OFF;
                    r_ramp_lim <= '0;
                end
            endcase
        end
    end

    assign bus.lft_spd  = r_lft_spd;
    assign bus.lft_rev  = r_lft_rev;
    assign bus.rght_spd = r_rght_spd;
    assign bus.rght_rev = r_rght_rev;
    assign bus.too_fast = r_too_fast;
    assign bus.spd_vld  = r_spd_vld;

endmodule
`default_nettype wire

// File: tb/tb_balance_pid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_balance_pid_pipe
// Description : Directed, table-driven bench for balance_pid_pipe. Expected
//               speeds are hand-computed from the PID/shaping equations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_balance_pid_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    balance_pid_pipe_if bus ();

    balance_pid_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int ptch;
        int ld;
        int es;
        int lspd;
        int lrev;
        int rspd;
        int rrev;
        int fast;
    } vec_t;

    vec_t vecs [13];

    int n_checks = 0;
    int n_pass   = 0;

`ifdef INTEG_CLAMP_EN
    localparam int c_integ_exp = 131071;
`else
    localparam int c_integ_exp = 130816;   // 256 * 511, last value before overflow
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p, input int ld, input int es);
        bus.ptch         = 16'(p);
        bus.ld_cell_diff = 12'(ld);
        bus.en_steer     = (es != 0);
        bus.vld          = 1'b1;
        tick();
        bus.vld          = 1'b0;
    endtask

    task automatic fresh();
        bus.rider_off = 1'b1;
        tick();
        bus.rider_off = 1'b0;
    endtask

    // Sample accepted at edge N; spd_vld visible after edge N+2 only
    task automatic send_chk(input string name, input vec_t v);
        send(v.ptch, v.ld, v.es);
        tick();
        chk({name, "_vld_early"}, int'(bus.spd_vld), 0);
        tick();
        chk({name, "_vld"},  int'(bus.spd_vld),  1);
        chk({name, "_lspd"}, int'(bus.lft_spd),  v.lspd);
        chk({name, "_lrev"}, int'(bus.lft_rev),  v.lrev);
        chk({name, "_rspd"}, int'(bus.rght_spd), v.rspd);
        chk({name, "_rrev"}, int'(bus.rght_rev), v.rrev);
        chk({name, "_fast"}, int'(bus.too_fast), v.fast);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int   seen;
        vec_t z;

        //            ptch    ld    es  lspd lrev rspd rrev fast
        vecs[0]  = '{     1,    0,  0,  510, 0,  510, 0, 0};
        vecs[1]  = '{    -1,    0,  0,  510, 1,  510, 1, 0};
        vecs[2]  = '{    16,    0,  0, 1524, 0, 1524, 0, 0};
        vecs[3]  = '{     1,   80,  1,  360, 0,  660, 0, 0};
        vecs[4]  = '{     0, -800,  1, 1080, 0, 1080, 1, 0};
        vecs[5]  = '{     1, -800,  0,  510, 0,  510, 0, 0};
        vecs[6]  = '{     0,  552,  1, 1035, 1, 1035, 0, 0};
        vecs[7]  = '{     0,  568,  1, 1051, 1, 1051, 0, 0};
        vecs[8]  = '{    16,   96,  1, 1512, 0, 1536, 0, 0};
        vecs[9]  = '{    16,  104,  1, 1511, 0, 1537, 0, 1};
        vecs[10] = '{-32768,    0,  0, 2047, 1, 2047, 1, 1};
        vecs[11] = '{   600,    0,  0, 2047, 0, 2047, 0, 1};
        vecs[12] = '{ 32767,    0,  0, 2047, 0, 2047, 0, 1};
        z        = '{     0,    0,  0,    0, 0,    0, 0, 0};

        bus.vld = 1'b0; bus.ptch = '0; bus.ld_cell_diff = '0;
        bus.rider_off = 1'b0; bus.en_steer = 1'b0; bus.pwr_up = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_lspd",  int'(bus.lft_spd),  0);
        chk("rst_rspd",  int'(bus.rght_spd), 0);
        chk("rst_lrev",  int'(bus.lft_rev),  0);
        chk("rst_rrev",  int'(bus.rght_rev), 0);
        chk("rst_fast",  int'(bus.too_fast), 0);
        chk("rst_vld",   int'(bus.spd_vld),  0);
        rst_n = 1'b1;
        tick();

        // Soft start: 8 zero-pitch samples take the limit to full scale
        bus.pwr_up = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send_chk("ramp", z);
        chk("ramp_lim_full", int'(dut.r_ramp_lim), 2047);

        // Main vectors, each from a fresh history
        for (int i = 0; i < 13; i++) begin
            fresh();
            send_chk($sformatf("vec%0d", i), vecs[i]);
        end

        // Power drop: outputs zero next cycle
        bus.pwr_up = 1'b0;
        tick();
        chk("pwroff_lspd", int'(bus.lft_spd),  0);
        chk("pwroff_fast", int'(bus.too_fast), 0);
        chk("pwroff_vld",  int'(bus.spd_vld),  0);

        // In-flight sample discarded by power drop
        bus.pwr_up = 1'b1;
        tick();
        send(16, 0, 0);
        bus.pwr_up = 1'b0;
        seen = 0;
        repeat (5) begin
            tick();
            if (bus.spd_vld) seen++;
        end
        chk("pwroff_inflight", seen, 0);

        // Restart: limit starts at zero, then one step
        bus.pwr_up = 1'b1;
        tick();
        fresh();
        send_chk("soft0", '{1, 0, 0, 0, 0, 0, 0, 0});
        send_chk("soft1", '{1, 0, 0, 256, 0, 256, 0, 0});

        // Integrator overflow, back-to-back samples
        fresh();
        seen = 0;
        bus.ptch = 16'h01FF; bus.ld_cell_diff = '0; bus.en_steer = 1'b0;
        bus.vld = 1'b1;
        repeat (300) begin
            tick();
            if (bus.spd_vld) seen++;
        end
        bus.vld = 1'b0;
        repeat (3) begin
            tick();
            if (bus.spd_vld) seen++;
        end
        chk("b2b_count", seen, 300);
        chk("integ_ovf", int'(dut.r_integ), c_integ_exp);
        chk("ovf_lspd",  int'(bus.lft_spd), 2047);
        chk("ovf_fast",  int'(bus.too_fast), 1);

        bus.rider_off = 1'b1;
        tick();
        bus.rider_off = 1'b0;
        chk("rider_clr_integ", int'(dut.r_integ), 0);

        // rider_off coincident with vld: clear wins
        send_chk("ro_a", '{16, 0, 0, 1524, 0, 1524, 0, 0});
        bus.rider_off = 1'b1;
        send(16, 0, 0);
        bus.rider_off = 1'b0;
        tick();
        tick();
        chk("ro_b_lspd", int'(bus.lft_spd), 1524);
        send_chk("ro_c", '{16, 0, 0, 1524, 0, 1524, 0, 0});

        // Reset mid-pipeline: no spurious update afterwards
        send(16, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            tick();
            if (bus.spd_vld) seen++;
        end
        chk("midrst_vld",  seen, 0);
        chk("midrst_lspd", int'(bus.lft_spd), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
